// File: rtl/microwave_timer_ctrl_if.sv
// Front-panel bundle between keypad/tick sources and the cook timer: strobes and
// door level in, time digits and Moore status out.
interface microwave_timer_ctrl_if;
  logic       tick;
  logic       key_valid;
  logic [3:0] key_data;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       heating;
  logic       done;
  logic [2:0] state;

  modport master (
    output tick, key_valid, key_data, start, stop_clear, door_closed,
    input  min_tens, min_ones, sec_tens, sec_ones, heating, done, state
  );

  modport slave (
    input  tick, key_valid, key_data, start, stop_clear, door_closed,
    output min_tens, min_ones, sec_tens, sec_ones, heating, done, state
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook timer: keypad MM:SS entry, 1 Hz BCD countdown, pause/resume and
// a timed end-of-cook indication. All outputs are registered or decode the state register.
module microwave_timer_ctrl #(
  parameter int DONE_TICKS     = 3,
  parameter int QUICK_SEC_TENS = 3
) (
  input logic                   clk,
  input logic                   clr,
  microwave_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    COOK   = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  state_e        state_q, state_d;
  logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic key_ok, time_nz, time_one, start_ok;
  logic do_clear, do_shift, do_load, do_dec;

  assign key_ok   = bus.key_valid && (bus.key_data <= 4'd9);
  assign time_nz  = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} != 16'h0000;
  assign time_one = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0001;
  // Entered times with a seconds-tens above 5 are not valid clock times.
  assign start_ok = bus.start && bus.door_closed && (sec_tens_q <= 4'd5) && time_nz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_clear = 1'b0;
    do_shift = 1'b0;
    do_load  = 1'b0;
    do_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.stop_clear) do_clear = 1'b1;
        else if (bus.start && bus.door_closed) begin
          do_load = 1'b1;
          state_d = COOK;
        end else if (key_ok) begin
          do_shift = 1'b1;
          state_d  = ENTRY;
        end
      end
      ENTRY: begin
        if (bus.stop_clear) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (start_ok) state_d = COOK;
        else if (key_ok) do_shift = 1'b1;
      end
      COOK: begin
        if (bus.stop_clear || !bus.door_closed) state_d = PAUSED;
        else if (bus.tick) begin
          do_dec = 1'b1;
          if (time_one) state_d = DONE;
        end
      end
      PAUSED: begin
        if (bus.stop_clear) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (bus.start && bus.door_closed) state_d = COOK;
      end
      DONE: begin
        if (bus.stop_clear || !bus.door_closed) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.tick) begin
          if (cnt_q == CW'(DONE_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (do_clear) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (do_load) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'(QUICK_SEC_TENS);
      sec_ones_d = 4'd0;
    end else if (do_shift) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = bus.key_data;
    end else if (do_dec) begin
      // Borrow chain; COOK never holds 00:00, so min_tens never underflows.
      if (sec_ones_q != 4'd0) sec_ones_d = sec_ones_q - 4'd1;
      else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) sec_tens_d = sec_tens_q - 4'd1;
        else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) min_ones_d = min_ones_q - 4'd1;
          else begin
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign bus.min_tens = min_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.sec_ones = sec_ones_q;
  assign bus.state    = state_q;
  assign bus.heating  = (state_q == COOK);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed front-panel scenarios, then random panel
// activity, all compared against a seconds-based reference model.
module tb_microwave_timer_ctrl;
  localparam int DT = 3;

  logic clk = 1'b0;
  logic clr;
  int   passed = 0;
  int   total  = 0;

  // Reference model: state code, digits {mt, mo, st, so}, done tick count.
  int m_state;
  int m_d[4];
  int m_cnt;

  microwave_timer_ctrl_if bus();

  microwave_timer_ctrl #(.DONE_TICKS(DT), .QUICK_SEC_TENS(3)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int m_secs();
    return (m_d[0] * 10 + m_d[1]) * 60 + m_d[2] * 10 + m_d[3];
  endfunction

  function automatic int m_packed();
    return (m_d[0] << 12) | (m_d[1] << 8) | (m_d[2] << 4) | m_d[3];
  endfunction

  task automatic m_set(input int s);
    m_d[0] = (s / 60) / 10;
    m_d[1] = (s / 60) % 10;
    m_d[2] = (s % 60) / 10;
    m_d[3] = s % 10;
  endtask

  task automatic m_reset();
    m_state = 0;
    m_cnt   = 0;
    m_set(0);
  endtask

  task automatic m_step(input bit tk, input bit kv, input int kd, input bit st, input bit sc,
                        input bit door);
    if (sc) begin
      if (m_state == 2) m_state = 3;
      else if (m_state == 4) begin m_state = 0; m_cnt = 0; end
      else begin m_set(0); m_state = 0; end
    end else if (!door && m_state == 2) m_state = 3;
    else if (!door && m_state == 4) begin m_state = 0; m_cnt = 0; end
    else if (st && door && m_state == 0) begin m_set(30); m_state = 2; end
    else if (st && door && m_state == 1 && m_d[2] <= 5 && m_secs() != 0) m_state = 2;
    else if (st && door && m_state == 3) m_state = 2;
    else if (kv && kd <= 9 && (m_state == 0 || m_state == 1)) begin
      m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = m_d[3]; m_d[3] = kd;
      m_state = 1;
    end else if (tk && m_state == 2) begin
      m_set(m_secs() - 1);
      if (m_secs() == 0) m_state = 4;
    end else if (tk && m_state == 4) begin
      m_cnt++;
      if (m_cnt == DT) begin m_cnt = 0; m_state = 0; end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int dut_digits();
    return {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, " state"}, int'(bus.state), m_state);
    chk({tag, " digits"}, dut_digits(), m_packed());
    chk({tag, " heating"}, int'(bus.heating), int'(m_state == 2));
    chk({tag, " done"}, int'(bus.done), int'(m_state == 4));
  endtask

  task automatic cyc(input bit tk, input bit kv, input int kd, input bit st, input bit sc);
    bus.tick       = tk;
    bus.key_valid  = kv;
    bus.key_data   = 4'(kd);
    bus.start      = st;
    bus.stop_clear = sc;
    m_step(tk, kv, kd, st, sc, bus.door_closed);
    @(posedge clk);
    #1;
    bus.tick = 0; bus.key_valid = 0; bus.start = 0; bus.stop_clear = 0;
    chk_all("cyc");
  endtask

  task automatic key(input int k); cyc(0, 1, k, 0, 0); endtask
  task automatic tick1();          cyc(1, 0, 0, 0, 0); endtask
  task automatic start1();         cyc(0, 0, 0, 1, 0); endtask
  task automatic stop1();          cyc(0, 0, 0, 0, 1); endtask

  initial begin
    bus.tick = 0; bus.key_valid = 0; bus.key_data = 0; bus.start = 0;
    bus.stop_clear = 0; bus.door_closed = 1;
    clr = 1;
    m_reset();
    #12;
    chk_all("reset");
    @(posedge clk); #1;
    clr = 0;

    // 01:30 countdown across the minute boundary
    key(1); key(3); key(0); start1();
    chk("t1 loaded", dut_digits(), 16'h0130);
    chk("t1 heating", int'(bus.heating), 1);
    for (int i = 1; i <= 31; i++) begin
      tick1();
      if (i == 30) chk("t1 tick30", dut_digits(), 16'h0100);
      if (i == 31) chk("t1 tick31", dut_digits(), 16'h0059);
    end
    stop1(); stop1();

    // 00:02 to DONE, then DONE times out
    key(2); start1(); tick1(); tick1();
    chk("t2 done state", int'(bus.state), 4);
    chk("t2 heating off", int'(bus.heating), 0);
    chk("t2 digits", dut_digits(), 16'h0000);
    tick1(); tick1();
    chk("t2 still done", int'(bus.done), 1);
    tick1();
    chk("t2 idle", int'(bus.state), 0);
    chk("t2 done off", int'(bus.done), 0);

    // Door opens together with a tick at 00:45
    key(4); key(5); start1();
    bus.door_closed = 0;
    tick1();
    chk("t3 paused", int'(bus.state), 3);
    chk("t3 held", dut_digits(), 16'h0045);
    bus.door_closed = 1;
    start1(); tick1();
    chk("t3 resumed", dut_digits(), 16'h0044);
    stop1(); stop1();

    // Invalid start attempts and out-of-range key
    key(7); key(0); start1();
    chk("t4 entry", int'(bus.state), 1);
    stop1();
    chk("t4 cleared", dut_digits(), 16'h0000);
    key(12);
    chk("t4 key12 state", int'(bus.state), 0);
    key(0); start1();
    chk("t4 zero start", int'(bus.state), 1);
    stop1();

    // Shift-out of the first digit, minute borrow
    key(1); key(2); key(3); key(4); key(5);
    chk("t5 shifted", dut_digits(), 16'h2345);
    stop1();
    key(1); key(0); key(0); key(0); start1(); tick1();
    chk("t5 borrow", dut_digits(), 16'h0959);
    stop1(); stop1();

    // Quick start, then asynchronous clear mid-cook
    start1();
    chk("t6 quick", dut_digits(), 16'h0030);
    #2;
    clr = 1;
    m_reset();
    #1;
    chk("t6 async heating", int'(bus.heating), 0);
    chk("t6 async digits", dut_digits(), 16'h0000);
    chk("t6 async state", int'(bus.state), 0);
    @(posedge clk); #1;
    clr = 0;

    // Random panel activity
    for (int n = 0; n < 3000; n++) begin
      int ev;
      if ($urandom_range(0, 9) == 0) bus.door_closed = ~bus.door_closed;
      ev = int'($urandom_range(0, 19));
      if (ev < 6)       key(int'($urandom_range(0, 11)));
      else if (ev < 8)  start1();
      else if (ev < 9)  stop1();
      else if (ev < 16) tick1();
      else              cyc(0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
